// File: rtl/mem_bus_unit_pkg.sv
// Shared types and constants for the load/store bus master.
package mem_bus_unit_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_BE_W   = 4;
    localparam int unsigned MEM_TMO_W  = 16;

    localparam logic [1:0] MEM_UNIT_BYTE = 2'b00;
    localparam logic [1:0] MEM_UNIT_HALF = 2'b01;
    localparam logic [1:0] MEM_UNIT_WORD = 2'b10;

    typedef enum logic [1:0] {
        MEM_FAULT_NONE       = 2'd0,
        MEM_FAULT_MISALIGNED = 2'd1,
        MEM_FAULT_ACCESS     = 2'd2
    } mem_fault_t;

    typedef enum logic [1:0] {
        MEM_BUS_IDLE = 2'd0,
        MEM_BUS_ADDR = 2'd1,
        MEM_BUS_RESP = 2'd2,
        MEM_BUS_DONE = 2'd3
    } mem_bus_state_t;

    // Address-phase payload held stable on the bus until accepted.
    typedef struct packed {
        logic [MEM_ADDR_W-1:0] addr;
        logic                  we;
        logic [MEM_BE_W-1:0]   be;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_bus_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and alignment check for all accesses.
module mem_lane_align
    import mem_bus_unit_pkg::*;
(
    input  logic [1:0]            addr_lo_i,
    input  logic [1:0]            unit_i,
    input  logic [MEM_DATA_W-1:0] wd_i,
    output logic [MEM_BE_W-1:0]   be_c,
    output logic [MEM_DATA_W-1:0] wdata_c,
    output logic                  misaligned_c
);

    // Lane enables, replicated store data and misalignment per access size.
    always_comb begin
        be_c         = '0;
        wdata_c      = '0;
        misaligned_c = 1'b0;
        case (unit_i)
            MEM_UNIT_BYTE: begin
                be_c    = 4'b0001 << addr_lo_i;
                wdata_c = {4{wd_i[7:0]}};
            end
            MEM_UNIT_HALF: begin
                be_c         = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_c      = {2{wd_i[15:0]}};
                misaligned_c = addr_lo_i[0];
            end
            MEM_UNIT_WORD: begin
                be_c         = 4'b1111;
                wdata_c      = wd_i;
                misaligned_c = |addr_lo_i;
            end
            default: begin
                misaligned_c = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_unit.sv
// Load/store bus master: alignment check, valid/ready address phase,
// rvalid response phase, timeout, and lane-shifted read return.
module mem_bus_unit
    import mem_bus_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [MEM_ADDR_W-1:0] addr,
    input  logic [MEM_DATA_W-1:0] wd,
    input  logic [1:0]            unit,
    output logic [MEM_DATA_W-1:0] rd,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output mem_fault_t            fault_code,
    output logic [MEM_ADDR_W-1:0] fault_addr,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic [MEM_ADDR_W-1:0] bus_addr,
    output logic                  bus_we,
    output logic [MEM_BE_W-1:0]   bus_be,
    output logic [MEM_DATA_W-1:0] bus_wdata,
    input  logic                  bus_rvalid,
    input  logic [MEM_DATA_W-1:0] bus_rdata
);

    localparam logic [MEM_TMO_W-1:0] TMO_LAST = MEM_TMO_W'(TIMEOUT_CYCLES - 32'd1);

    mem_bus_state_t        state_q, state_d;
    mem_bus_req_t          breq_q, breq_d;
    mem_fault_t            code_q, code_d;
    logic [MEM_TMO_W-1:0]  cnt_q, cnt_d;
    logic [MEM_DATA_W-1:0] rd_q, rd_d;
    logic [MEM_ADDR_W-1:0] fault_addr_q, fault_addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  fault_q, fault_d;
    logic                  valid_q, valid_d;

    logic [MEM_BE_W-1:0]   be_c;
    logic [MEM_DATA_W-1:0] wdata_c;
    logic                  misaligned_c;
    logic [MEM_DATA_W-1:0] rdata_shift_c;
    logic                  tmo_c;

    mem_lane_align u_lane_align (
        .addr_lo_i    (addr[1:0]),
        .unit_i       (unit),
        .wd_i         (wd),
        .be_c         (be_c),
        .wdata_c      (wdata_c),
        .misaligned_c (misaligned_c)
    );

    // fault_addr holds the captured address, so its low bits select the read lane.
    assign rdata_shift_c = bus_rdata >> {fault_addr_q[1:0], 3'b000};
    assign tmo_c         = (cnt_q == TMO_LAST);

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        breq_d       = breq_q;
        code_d       = MEM_FAULT_NONE;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        fault_addr_d = fault_addr_q;
        done_d       = 1'b0;
        fault_d      = 1'b0;
        valid_d      = valid_q;
        case (state_q)
            MEM_BUS_IDLE: begin
                if (req) begin
                    fault_addr_d = addr;
                    if (misaligned_c) begin
                        state_d = MEM_BUS_DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        code_d  = MEM_FAULT_MISALIGNED;
                    end else begin
                        state_d      = MEM_BUS_ADDR;
                        valid_d      = 1'b1;
                        breq_d.addr  = {addr[MEM_ADDR_W-1:2], 2'b00};
                        breq_d.we    = we;
                        breq_d.be    = be_c;
                        breq_d.wdata = wdata_c;
                        cnt_d        = '0;
                    end
                end
            end
            MEM_BUS_ADDR: begin
                cnt_d = cnt_q + MEM_TMO_W'(1);
                if (bus_ready && bus_rvalid) begin
                    state_d = MEM_BUS_DONE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    if (!breq_q.we) begin
                        rd_d = rdata_shift_c;
                    end
                end else if (tmo_c) begin
                    state_d = MEM_BUS_DONE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                    code_d  = MEM_FAULT_ACCESS;
                end else if (bus_ready) begin
                    state_d = MEM_BUS_RESP;
                    valid_d = 1'b0;
                end
            end
            MEM_BUS_RESP: begin
                cnt_d = cnt_q + MEM_TMO_W'(1);
                if (bus_rvalid) begin
                    state_d = MEM_BUS_DONE;
                    done_d  = 1'b1;
                    if (!breq_q.we) begin
                        rd_d = rdata_shift_c;
                    end
                end else if (tmo_c) begin
                    state_d = MEM_BUS_DONE;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                    code_d  = MEM_FAULT_ACCESS;
                end
            end
            MEM_BUS_DONE: begin
                state_d = MEM_BUS_IDLE;
            end
            default: begin
                state_d = MEM_BUS_IDLE;
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != MEM_BUS_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= MEM_BUS_IDLE;
            breq_q       <= '0;
            code_q       <= MEM_FAULT_NONE;
            cnt_q        <= '0;
            rd_q         <= '0;
            fault_addr_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            breq_q       <= breq_d;
            code_q       <= code_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            fault_addr_q <= fault_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            valid_q      <= valid_d;
        end
    end

    assign rd         = rd_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign fault_addr = fault_addr_q;
    assign bus_valid  = valid_q;
    assign bus_addr   = breq_q.addr;
    assign bus_we     = breq_q.we;
    assign bus_be     = breq_q.be;
    assign bus_wdata  = breq_q.wdata;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Bench for mem_bus_unit: directed vector table, hand sequences, random model checks.
module tb_mem_bus_unit;
    import mem_bus_unit_pkg::*;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  unit;
    logic [31:0] rd;
    logic        busy;
    logic        done;
    logic        fault;
    mem_fault_t  fault_code;
    logic [31:0] fault_addr;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] rd_m;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  u;
        logic [31:0] rdata;
        int          dr;
        int          dv;
        logic        ef;
        mem_fault_t  ec;
        logic [31:0] erd;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        int          lat;
    } vec_t;

    vec_t tbl[9];

    mem_bus_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wd         (wd),
        .unit       (unit),
        .rd         (rd),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_addr (fault_addr),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_addr   (bus_addr),
        .bus_we     (bus_we),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mkv(input logic w, input logic [31:0] a, input logic [31:0] wdv,
                                 input logic [1:0] u, input logic [31:0] rdata, input int dr,
                                 input int dv, input logic ef, input mem_fault_t ec,
                                 input logic [31:0] erd, input logic [3:0] ebe,
                                 input logic [31:0] ewd, input int lat);
        vec_t v;
        v.we = w; v.a = a; v.wd = wdv; v.u = u; v.rdata = rdata; v.dr = dr; v.dv = dv;
        v.ef = ef; v.ec = ec; v.erd = erd; v.ebe = ebe; v.ewd = ewd; v.lat = lat;
        return v;
    endfunction

    // Reference model: access size, lane positions and cycle count from plain arithmetic.
    function automatic vec_t model(input logic w, input logic [31:0] a, input logic [31:0] wdv,
                                   input logic [1:0] u, input logic [31:0] rdata,
                                   input int dr, input int dv, input logic [31:0] rd_prev);
        vec_t v;
        int   size;
        int   off;
        int   need;
        logic mis;
        v.we = w; v.a = a; v.wd = wdv; v.u = u; v.rdata = rdata; v.dr = dr; v.dv = dv;
        off  = int'(a % 4);
        size = (u == 2'd0) ? 1 : (u == 2'd1) ? 2 : 4;
        mis  = (u == 2'd3) || (off % size != 0);
        v.ebe = '0;
        v.ewd = '0;
        for (int i = 0; i < 4; i++) begin
            v.ebe[i] = (i >= off) && (i < off + size);
            v.ewd[8*i +: 8] = wdv[8*(i % size) +: 8];
        end
        need = dr + dv + 1;
        if (mis) begin
            v.ef = 1'b1; v.ec = MEM_FAULT_MISALIGNED; v.lat = 0; v.erd = rd_prev;
        end else if (need > T) begin
            v.ef = 1'b1; v.ec = MEM_FAULT_ACCESS; v.lat = T; v.erd = rd_prev;
        end else begin
            v.ef = 1'b0; v.ec = MEM_FAULT_NONE; v.lat = need;
            v.erd = w ? rd_prev : (rdata >> (8 * off));
        end
        return v;
    endfunction

    // Issue one request, play the bus side, and check every cycle until after done.
    task automatic run_access(input vec_t v, input string tag);
        logic mis;
        logic exp_valid;
        mis = v.ef && (v.ec == MEM_FAULT_MISALIGNED);
        @(negedge clk);
        req = 1'b1; we = v.we; addr = v.a; wd = v.wd; unit = v.u; bus_rdata = v.rdata;
        for (int c = 0; c <= v.lat + 1; c++) begin
            @(negedge clk);
            req = 1'b0;
            exp_valid = !mis && (c <= v.dr) && (c < v.lat);
            chk({tag, ".bus_valid"}, 32'(bus_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk({tag, ".bus_addr"}, bus_addr, {v.a[31:2], 2'b00});
                chk({tag, ".bus_be"}, 32'(bus_be), 32'(v.ebe));
                chk({tag, ".bus_wdata"}, bus_wdata, v.ewd);
                chk({tag, ".bus_we"}, 32'(bus_we), 32'(v.we));
            end
            chk({tag, ".busy"}, 32'(busy), 32'(c <= v.lat));
            chk({tag, ".done"}, 32'(done), 32'(c == v.lat));
            if (c == v.lat) begin
                chk({tag, ".fault"}, 32'(fault), 32'(v.ef));
                chk({tag, ".fault_code"}, 32'(fault_code), 32'(v.ec));
                chk({tag, ".rd"}, rd, v.erd);
                chk({tag, ".fault_addr"}, fault_addr, v.a);
            end
            bus_ready  = (c == v.dr) && (c < v.lat);
            bus_rvalid = (c == v.dr + v.dv) && (c < v.lat);
        end
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        rd_m = v.erd;
    endtask

    initial begin
        vec_t v;
        reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wd = '0; unit = '0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        rd_m = '0;

        tbl[0] = mkv(1'b0, 32'h8000_0104, 32'h0, 2'd2, 32'hDEAD_BEEF, 0, 1,
                     1'b0, MEM_FAULT_NONE, 32'hDEAD_BEEF, 4'b1111, 32'h0, 2);
        tbl[1] = mkv(1'b0, 32'h8000_0103, 32'h0, 2'd0, 32'hAB11_2233, 0, 0,
                     1'b0, MEM_FAULT_NONE, 32'h0000_00AB, 4'b1000, 32'h0, 1);
        tbl[2] = mkv(1'b1, 32'h8000_0202, 32'h0000_1234, 2'd1, 32'h0, 5, 1,
                     1'b0, MEM_FAULT_NONE, 32'h0000_00AB, 4'b1100, 32'h1234_1234, 7);
        tbl[3] = mkv(1'b0, 32'h8000_0101, 32'h0, 2'd2, 32'h0, 0, 0,
                     1'b1, MEM_FAULT_MISALIGNED, 32'h0000_00AB, 4'b0000, 32'h0, 0);
        tbl[4] = mkv(1'b0, 32'h8000_0100, 32'h0, 2'd3, 32'h0, 0, 0,
                     1'b1, MEM_FAULT_MISALIGNED, 32'h0000_00AB, 4'b0000, 32'h0, 0);
        tbl[5] = mkv(1'b0, 32'h8000_0002, 32'h0, 2'd1, 32'hCAFE_F00D, 1, 0,
                     1'b0, MEM_FAULT_NONE, 32'h0000_CAFE, 4'b1100, 32'h0, 2);
        tbl[6] = mkv(1'b0, 32'h8000_0010, 32'h0, 2'd2, 32'h0, 100, 0,
                     1'b1, MEM_FAULT_ACCESS, 32'h0000_CAFE, 4'b1111, 32'h0, 8);
        tbl[7] = mkv(1'b1, 32'h8000_0001, 32'hFFFF_FF5A, 2'd0, 32'h0, 0, 2,
                     1'b0, MEM_FAULT_NONE, 32'h0000_CAFE, 4'b0010, 32'h5A5A_5A5A, 3);
        tbl[8] = mkv(1'b0, 32'h8000_0002, 32'h0, 2'd0, 32'h00C3_0000, 3, 4,
                     1'b0, MEM_FAULT_NONE, 32'h0000_00C3, 4'b0100, 32'h0, 8);

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.bus_valid", 32'(bus_valid), 32'h0);
        chk("rst.done", 32'(done), 32'h0);
        chk("rst.fault", 32'(fault), 32'h0);
        chk("rst.fault_code", 32'(fault_code), 32'(MEM_FAULT_NONE));
        chk("rst.rd", rd, 32'h0);
        chk("rst.fault_addr", fault_addr, 32'h0);
        chk("rst.bus_addr", bus_addr, 32'h0);
        chk("rst.bus_be", 32'(bus_be), 32'h0);
        chk("rst.bus_wdata", bus_wdata, 32'h0);
        chk("rst.bus_we", 32'(bus_we), 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_access(tbl[i], $sformatf("vec%0d", i));
            if (i == 6) begin
                // Late response after a timeout must not produce a completion.
                bus_rvalid = 1'b1; bus_ready = 1'b1; bus_rdata = 32'h1111_2222;
                @(negedge clk);
                bus_rvalid = 1'b0; bus_ready = 1'b0;
                chk("late.done", 32'(done), 32'h0);
                chk("late.busy", 32'(busy), 32'h0);
                @(negedge clk);
                chk("late.done2", 32'(done), 32'h0);
                chk("late.rd", rd, rd_m);
            end
        end

        // req held through DONE is not accepted there.
        @(negedge clk);
        req = 1'b1; unit = 2'd3; addr = 32'h8000_0300;
        @(negedge clk);
        chk("hold.done", 32'(done), 32'h1);
        @(negedge clk);
        req = 1'b0;
        chk("hold.busy", 32'(busy), 32'h0);
        chk("hold.done_off", 32'(done), 32'h0);

        // Reset while waiting for the response.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h8000_0008; unit = 2'd2;
        @(negedge clk);
        req = 1'b0; bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        chk("mid.busy_resp", 32'(busy), 32'h1);
        chk("mid.valid_resp", 32'(bus_valid), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mid.busy", 32'(busy), 32'h0);
        chk("mid.bus_valid", 32'(bus_valid), 32'h0);
        chk("mid.rd", rd, 32'h0);
        chk("mid.done", 32'(done), 32'h0);
        chk("mid.fault_addr", fault_addr, 32'h0);
        chk("mid.bus_be", 32'(bus_be), 32'h0);
        bus_rvalid = 1'b1; bus_rdata = 32'h7777_8888;
        @(negedge clk);
        bus_rvalid = 1'b0;
        chk("mid.stray_done", 32'(done), 32'h0);
        chk("mid.stray_rd", rd, 32'h0);
        rd_m = '0;
        v = model(1'b0, 32'h8000_0024, 32'h0, 2'd2, 32'h0BAD_F00D, 1, 1, rd_m);
        run_access(v, "mid.after");

        // Randomized accesses against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  u;
            logic [31:0] a;
            u = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (u == 2'd2) a[1:0] = 2'b00;
                if (u == 2'd1) a[0] = 1'b0;
            end
            v = model(1'($urandom_range(0, 1)), a, $urandom, u, $urandom,
                      $urandom_range(0, 4), $urandom_range(0, 4), rd_m);
            run_access(v, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
